// File: rtl/conv_pkg.sv
// Shared constants for the binary convolution datapath (conv_module array and its back end).
package conv_pkg;

    localparam int unsigned NUM_TAPS   = 9;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned NEG_THRESH = NUM_TAPS / 2;

    // Width needed to hold a count of 0..taps.
    function automatic int unsigned cnt_width(input int unsigned taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/tap_popcount.sv
// Combinational population count of the per-tap negative flags.
module tap_popcount
    import conv_pkg::*;
#(
    parameter int unsigned N_TAPS = NUM_TAPS,
    parameter int unsigned CNT_W  = cnt_width(NUM_TAPS)
) (
    input  logic [N_TAPS-1:0] flags,
    output logic [CNT_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N_TAPS; i++) begin
            count = count + CNT_W'(flags[i]);
        end
    end

endmodule

// File: rtl/conv_row_writer.sv
// Thresholds per-pixel negative counts into output bits, packs them into row words
// and writes each completed row to the output SRAM.
module conv_row_writer #(
    parameter int unsigned       NUM_TAPS  = conv_pkg::NUM_TAPS,
    parameter int unsigned       WORD_W    = conv_pkg::WORD_W,
    parameter int unsigned       ADDR_W    = conv_pkg::ADDR_W,
    parameter int unsigned       IDX_W     = conv_pkg::IDX_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pix_valid,
    input  logic [NUM_TAPS-1:0] neg_flags,
    input  logic [IDX_W-1:0]    idx_in,
    input  logic                row_last,
    input  logic                frame_last,
    input  logic                addr_clear,
    output logic                sram_write_enable,
    output logic [ADDR_W-1:0]   sram_write_address,
    output logic [WORD_W-1:0]   sram_write_data,
    output logic                frame_done,
    output logic                idx_err
);

    localparam int unsigned CNT_W  = conv_pkg::cnt_width(NUM_TAPS);
    localparam int unsigned THRESH = NUM_TAPS / 2;

    logic [CNT_W-1:0]  pop_cnt;
    logic [CNT_W-1:0]  s1_cnt;
    logic              s1_valid;
    logic              s1_row_last;
    logic              s1_frame_last;
    logic [IDX_W-1:0]  s1_idx;

    logic              s1_bit;
    logic              s1_idx_ok;
    logic              s1_row_end;
    logic [WORD_W-1:0] merged;

    logic [WORD_W-1:0] row_reg;
    logic [ADDR_W-1:0] addr_cnt;
    logic              w_valid;
    logic              w_frame;
    logic [WORD_W-1:0] w_data;
    logic [ADDR_W-1:0] w_addr;

    tap_popcount #(
        .N_TAPS(NUM_TAPS),
        .CNT_W (CNT_W)
    ) u_popcount (
        .flags(neg_flags),
        .count(pop_cnt)
    );

    // Merged word bypasses the current pixel's bit so a row can close on the same edge.
    always_comb begin
        s1_bit     = (32'(s1_cnt) <= THRESH);
        s1_idx_ok  = (32'(s1_idx) < WORD_W);
        s1_row_end = s1_valid && s1_row_last;
        merged     = row_reg;
        if (s1_valid && s1_idx_ok) begin
            merged[s1_idx] = s1_bit;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid      <= 1'b0;
            s1_cnt        <= '0;
            s1_idx        <= '0;
            s1_row_last   <= 1'b0;
            s1_frame_last <= 1'b0;
        end else begin
            s1_valid      <= pix_valid;
            s1_cnt        <= pop_cnt;
            s1_idx        <= idx_in;
            s1_row_last   <= pix_valid && row_last;
            s1_frame_last <= pix_valid && row_last && frame_last;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            row_reg  <= '0;
            addr_cnt <= BASE_ADDR;
            w_valid  <= 1'b0;
            w_frame  <= 1'b0;
            w_data   <= '0;
            w_addr   <= '0;
            idx_err  <= 1'b0;
        end else begin
            w_valid <= s1_row_end;
            if (s1_valid && !s1_idx_ok) begin
                idx_err <= 1'b1;
            end
            if (s1_row_end) begin
                row_reg <= '0;
                w_data  <= merged;
                w_addr  <= addr_cnt;
                w_frame <= s1_frame_last;
            end else begin
                row_reg <= merged;
            end
            // A clear coinciding with a row write lets that write keep the old address.
            if (addr_clear) begin
                addr_cnt <= BASE_ADDR;
            end else if (s1_row_end) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sram_write_enable  <= 1'b0;
            sram_write_address <= '0;
            sram_write_data    <= '0;
            frame_done         <= 1'b0;
        end else begin
            sram_write_enable <= w_valid;
            frame_done        <= w_valid && w_frame;
            if (w_valid) begin
                sram_write_address <= w_addr;
                sram_write_data    <= w_data;
            end
        end
    end

endmodule
